// File: rtl/alsaqr_pad_pkg.sv
// Shared types for the AlSaqr GPIO pad-ring control slice: pad direction encoding,
// synchroniser depth and the per-pad bundle driven toward the pad cell.
package alsaqr_pad_pkg;

    typedef enum logic {
        PAD_IN  = 1'b0,
        PAD_OUT = 1'b1
    } pad_dir_e;

    localparam int unsigned SYNC_STAGES = 2;

    typedef struct packed {
        logic oen;
        logic i;
    } pad_ctrl_t;

endpackage

// File: rtl/alsaqr_pad_glitch_filter.sv
// Single-pad glitch filter: a synchronised input must hold a new level for
// filt_len_i+1 consecutive cycles before it replaces the stable value.
module alsaqr_pad_glitch_filter #(
    parameter int FILT_CNT_W = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [FILT_CNT_W-1:0] filt_len_i,
    input  logic                  sync_i,
    output logic                  stb_o
);

    logic [FILT_CNT_W-1:0] cnt_p2;
    logic                  stb_p2;

    // Increment that holds at all-ones instead of wrapping.
    function automatic logic [FILT_CNT_W-1:0] sat_inc(input logic [FILT_CNT_W-1:0] v);
        return (&v) ? v : v + FILT_CNT_W'(1);
    endfunction

    // Filter stage: count cycles of disagreement, accept once the count reaches filt_len_i.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_p2 <= '0;
            stb_p2 <= 1'b0;
        end else if (sync_i == stb_p2) begin
            cnt_p2 <= '0;
        end else if (cnt_p2 < filt_len_i) begin
            cnt_p2 <= sat_inc(cnt_p2);
        end else begin
            stb_p2 <= sync_i;
            cnt_p2 <= '0;
        end
    end

    assign stb_o = stb_p2;

endmodule

// File: rtl/alsaqr_gpio_pad_ctrl.sv
// GPIO pad control: registered OEN/I toward the pads, synchronised (optionally filtered)
// pad inputs, edge detection and sticky interrupt status. Filter enabled by ALSAQR_PAD_GLITCH_FILTER_EN.
module alsaqr_gpio_pad_ctrl
    import alsaqr_pad_pkg::*;
#(
    parameter int NUM_PADS   = 32,
    parameter int FILT_CNT_W = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NUM_PADS-1:0]   gpio_out_i,
    input  logic [NUM_PADS-1:0]   gpio_dir_i,
    output logic [NUM_PADS-1:0]   gpio_in_o,
    output logic [NUM_PADS-1:0]   pad_i_o,
    output logic [NUM_PADS-1:0]   pad_oen_o,
    input  logic [NUM_PADS-1:0]   pad_o_i,
    input  logic [FILT_CNT_W-1:0] filt_len_i,
    input  logic [NUM_PADS-1:0]   irq_rise_en_i,
    input  logic [NUM_PADS-1:0]   irq_fall_en_i,
    input  logic [NUM_PADS-1:0]   irq_clr_i,
    output logic [NUM_PADS-1:0]   irq_status_o,
    output logic                  irq_o
);

    logic [NUM_PADS-1:0] sync_p1;
    logic [NUM_PADS-1:0] stb_p2;
    logic [NUM_PADS-1:0] stb_p3;
    logic [NUM_PADS-1:0] rise;
    logic [NUM_PADS-1:0] fall;
    logic [NUM_PADS-1:0] irq_set;
    logic [NUM_PADS-1:0] irq_status_q;

    for (genvar g = 0; g < NUM_PADS; g++) begin : g_pad
        logic [SYNC_STAGES-1:0] sync_sr;
        pad_ctrl_t              pad_q;

        // Synchroniser stages: pad O is asynchronous to clk_i.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                sync_sr <= '0;
            end else begin
                sync_sr <= {sync_sr[SYNC_STAGES-2:0], pad_o_i[g]};
            end
        end
        assign sync_p1[g] = sync_sr[SYNC_STAGES-1];

        // Output stage: pad controls come straight from flops so the pad never sees a glitch.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                pad_q <= '{oen: 1'b1, i: 1'b0};
            end else begin
                pad_q.oen <= (pad_dir_e'(gpio_dir_i[g]) == PAD_IN);
                pad_q.i   <= gpio_out_i[g];
            end
        end
        assign pad_oen_o[g] = pad_q.oen;
        assign pad_i_o[g]   = pad_q.i;

`ifdef ALSAQR_PAD_GLITCH_FILTER_EN
        alsaqr_pad_glitch_filter #(
            .FILT_CNT_W (FILT_CNT_W)
        ) u_filt (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .filt_len_i (filt_len_i),
            .sync_i     (sync_p1[g]),
            .stb_o      (stb_p2[g])
        );
`else
        assign stb_p2[g] = sync_p1[g];
`endif
    end

`ifndef ALSAQR_PAD_GLITCH_FILTER_EN
    logic unused_filt_len;
    assign unused_filt_len = ^filt_len_i;
`endif

    assign gpio_in_o = stb_p2;

    // Edge-detect stage: previous stable value, sampled regardless of pad direction.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stb_p3 <= '0;
        end else begin
            stb_p3 <= stb_p2;
        end
    end

    assign rise    = stb_p2 & ~stb_p3;
    assign fall    = ~stb_p2 & stb_p3;
    assign irq_set = (rise & irq_rise_en_i) | (fall & irq_fall_en_i);

    // Status stage: a new edge beats a simultaneous clear so no event is lost.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_status_q <= '0;
        end else begin
            irq_status_q <= irq_set | (irq_status_q & ~irq_clr_i);
        end
    end

    assign irq_status_o = irq_status_q;
    assign irq_o        = |irq_status_q;

endmodule

// File: tb/tb_alsaqr_gpio_pad_ctrl.sv
// Directed bench for alsaqr_gpio_pad_ctrl; expectations follow ALSAQR_PAD_GLITCH_FILTER_EN.
module tb_alsaqr_gpio_pad_ctrl;

    localparam int NUM_PADS   = 32;
    localparam int FILT_CNT_W = 4;
`ifdef ALSAQR_PAD_GLITCH_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif
    localparam int LAT0 = FILT ? 3 : 2;

    logic                  clk_i;
    logic                  rst_ni;
    logic [NUM_PADS-1:0]   gpio_out_i;
    logic [NUM_PADS-1:0]   gpio_dir_i;
    logic [NUM_PADS-1:0]   gpio_in_o;
    logic [NUM_PADS-1:0]   pad_i_o;
    logic [NUM_PADS-1:0]   pad_oen_o;
    logic [NUM_PADS-1:0]   pad_o_i;
    logic [FILT_CNT_W-1:0] filt_len_i;
    logic [NUM_PADS-1:0]   irq_rise_en_i;
    logic [NUM_PADS-1:0]   irq_fall_en_i;
    logic [NUM_PADS-1:0]   irq_clr_i;
    logic [NUM_PADS-1:0]   irq_status_o;
    logic                  irq_o;

    int n_cmp = 0;
    int n_err = 0;

    alsaqr_gpio_pad_ctrl #(
        .NUM_PADS   (NUM_PADS),
        .FILT_CNT_W (FILT_CNT_W)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .gpio_out_i    (gpio_out_i),
        .gpio_dir_i    (gpio_dir_i),
        .gpio_in_o     (gpio_in_o),
        .pad_i_o       (pad_i_o),
        .pad_oen_o     (pad_oen_o),
        .pad_o_i       (pad_o_i),
        .filt_len_i    (filt_len_i),
        .irq_rise_en_i (irq_rise_en_i),
        .irq_fall_en_i (irq_fall_en_i),
        .irq_clr_i     (irq_clr_i),
        .irq_status_o  (irq_status_o),
        .irq_o         (irq_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic clear_all();
        irq_clr_i = '1;
        tick(1);
        irq_clr_i = '0;
        check_eq("clear_all", irq_status_o, 0);
    endtask

    // Pulse pad high for w cycles and follow gpio_in_o for run cycles.
    task automatic pulse_test(input int pad, input int w, input int len, input int run);
        int  lat;
        bit  acc;
        logic exp;
        lat = FILT ? 3 + len : 2;
        acc = !FILT || (w >= len + 1);
        filt_len_i   = FILT_CNT_W'(len);
        pad_o_i[pad] = 1'b1;
        for (int t = 1; t <= run; t++) begin
            tick(1);
            if (t == w) pad_o_i[pad] = 1'b0;
            exp = acc && (t >= lat) && (t <= w + lat - 1);
            check_eq($sformatf("gin p%0d w%0d l%0d t%0d", pad, w, len, t), gpio_in_o[pad], exp);
        end
        check_eq($sformatf("status p%0d w%0d l%0d", pad, w, len), irq_status_o[pad], acc);
    endtask

    initial begin
        rst_ni        = 1'b0;
        gpio_out_i    = '0;
        gpio_dir_i    = '0;
        pad_o_i       = '0;
        filt_len_i    = '0;
        irq_rise_en_i = '0;
        irq_fall_en_i = '0;
        irq_clr_i     = '0;
        tick(2);
        check_eq("rst oen", pad_oen_o, 32'hFFFF_FFFF);
        check_eq("rst i", pad_i_o, 0);
        check_eq("rst gin", gpio_in_o, 0);
        check_eq("rst status", irq_status_o, 0);
        check_eq("rst irq", irq_o, 0);
        rst_ni = 1'b1;
        tick(2);

        // Output path with one cycle of latency
        gpio_dir_i[3] = 1'b1;
        gpio_out_i[3] = 1'b1;
        check_eq("oen before edge", pad_oen_o[3], 1);
        tick(1);
        check_eq("oen after edge", pad_oen_o, 32'hFFFF_FFF7);
        check_eq("i after edge", pad_i_o, 32'h0000_0008);

        // Input filter and latency
        irq_rise_en_i[0] = 1'b1;
        irq_rise_en_i[2] = 1'b1;
        pulse_test(0, 3, 4, 14);
        clear_all();
        pulse_test(0, 10, 4, 20);
        clear_all();
        pulse_test(0, 1, 1, 8);
        clear_all();
        pulse_test(2, 1, 0, 8);
        clear_all();

        // Edge detection on pad 5: rise enabled, fall disabled
        filt_len_i       = '0;
        irq_rise_en_i[5] = 1'b1;
        irq_fall_en_i[5] = 1'b0;
        pad_o_i[5] = 1'b1;
        tick(LAT0 + 2);
        check_eq("rise status", irq_status_o, 32'h0000_0020);
        check_eq("rise irq", irq_o, 1);
        pad_o_i[5] = 1'b0;
        tick(LAT0 + 2);
        check_eq("fall ignored", irq_status_o, 32'h0000_0020);

        // Clear arriving in the same cycle as a new rise
        pad_o_i[5] = 1'b1;
        tick(LAT0);
        irq_clr_i[5] = 1'b1;
        tick(1);
        irq_clr_i[5] = 1'b0;
        check_eq("race set wins", irq_status_o[5], 1);
        irq_clr_i[5] = 1'b1;
        tick(1);
        irq_clr_i[5] = 1'b0;
        check_eq("lone clear", irq_status_o[5], 0);
        check_eq("lone clear irq", irq_o, 0);

        // Falling edge and status hold with enables dropped
        irq_rise_en_i[5] = 1'b0;
        irq_fall_en_i[5] = 1'b1;
        pad_o_i[5] = 1'b0;
        tick(LAT0 + 2);
        check_eq("fall status", irq_status_o, 32'h0000_0020);
        irq_fall_en_i[5] = 1'b0;
        tick(2);
        check_eq("status held", irq_status_o[5], 1);
        check_eq("irq held", irq_o, 1);

        // Reset in the middle of traffic
        pad_o_i[5] = 1'b1;
        tick(LAT0 + 2);
        check_eq("pre-reset gin", gpio_in_o[5], 1);
        rst_ni = 1'b0;
        #1;
        check_eq("mid rst oen", pad_oen_o, 32'hFFFF_FFFF);
        check_eq("mid rst irq", irq_o, 0);
        check_eq("mid rst gin", gpio_in_o, 0);
        check_eq("mid rst status", irq_status_o, 0);
        tick(1);
        rst_ni = 1'b1;
        tick(LAT0 - 1);
        check_eq("post rst gin low", gpio_in_o[5], 0);
        check_eq("post rst oen", pad_oen_o[3], 0);
        tick(1);
        check_eq("post rst gin high", gpio_in_o[5], 1);
        tick(2);
        check_eq("post rst no status", irq_status_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
